// File: rtl/hps_layer_pio_multi.sv
// Multi-channel Avalon-MM PIO: per-channel out set/clear, sticky edge capture, masked irq.
// Optional macro PIO_INSYNC_EN inserts a 2-flop synchronizer ahead of each input sample register.
module hps_layer_pio_multi #(
  parameter int                DATA_W    = 32,
  parameter int                NUM_CH    = 4,
  parameter int                EDGE_TYPE = 0,
  parameter logic [DATA_W-1:0] RESET_OUT = {DATA_W{1'b0}},
  parameter int                ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [DATA_W-1:0]        writedata,
  output logic [DATA_W-1:0]        readdata,
  input  logic [NUM_CH*DATA_W-1:0] in_port,
  output logic [NUM_CH*DATA_W-1:0] out_port,
  output logic [NUM_CH-1:0]        out_strobe,
  output logic                     irq
);
  localparam int         CH_W       = ADDR_W - 3;
  localparam logic [1:0] EDGE_SEL   = 2'(EDGE_TYPE);
  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_OUT_RB = 3'd1;
  localparam logic [2:0] REG_OUTSET = 3'd2;
  localparam logic [2:0] REG_OUTCLR = 3'd3;
  localparam logic [2:0] REG_MASK   = 3'd4;
  localparam logic [2:0] REG_CAP    = 3'd5;

  logic [DATA_W-1:0] out_r       [NUM_CH];
  logic [DATA_W-1:0] mask_r      [NUM_CH];
  logic [DATA_W-1:0] cap_r       [NUM_CH];
  logic [DATA_W-1:0] samp_r      [NUM_CH];
  logic [DATA_W-1:0] prev_r      [NUM_CH];
  logic [DATA_W-1:0] out_next_s  [NUM_CH];
  logic [DATA_W-1:0] mask_next_s [NUM_CH];
  logic [DATA_W-1:0] cap_next_s  [NUM_CH];
  logic [DATA_W-1:0] in_ch_s     [NUM_CH];
  logic [DATA_W-1:0] samp_src_s  [NUM_CH];
  logic [NUM_CH-1:0] sel_s;
  logic [NUM_CH-1:0] strobe_next_s;
  logic [NUM_CH-1:0] strobe_r;
  logic [DATA_W-1:0] rd_next_s;
  logic [DATA_W-1:0] readdata_r;
  logic              irq_next_s;
  logic              irq_r;
  logic              wr_s;
  logic [CH_W-1:0]   ch_s;
  logic [2:0]        reg_s;

  assign ch_s  = address[ADDR_W-1:3];
  assign reg_s = address[2:0];
  assign wr_s  = chipselect & ~write_n;

  function automatic logic [DATA_W-1:0] edge_evt(input logic [DATA_W-1:0] s,
                                                 input logic [DATA_W-1:0] p);
    case (EDGE_SEL)
      2'd0:    return s & ~p;
      2'd1:    return ~s & p;
      default: return s ^ p;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] reg_read(input logic [2:0]        r,
                                                 input logic [DATA_W-1:0] s,
                                                 input logic [DATA_W-1:0] o,
                                                 input logic [DATA_W-1:0] m,
                                                 input logic [DATA_W-1:0] cp);
    case (r)
      REG_DATA:   return s;
      REG_OUT_RB: return o;
      REG_MASK:   return m;
      REG_CAP:    return cp;
      default:    return {DATA_W{1'b0}};
    endcase
  endfunction

  // Channel indices beyond NUM_CH never match a select bit, so they read 0 and ignore writes.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign in_ch_s[c]                    = in_port[c*DATA_W +: DATA_W];
    assign out_port[c*DATA_W +: DATA_W] = out_r[c];
    assign sel_s[c]                      = (ch_s == CH_W'(c));
  end

`ifdef PIO_INSYNC_EN
  logic [DATA_W-1:0] sync1_r [NUM_CH];
  logic [DATA_W-1:0] sync2_r [NUM_CH];

  // Two-flop synchronizer for inputs from a foreign clock domain.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        sync1_r[c] <= {DATA_W{1'b0}};
        sync2_r[c] <= {DATA_W{1'b0}};
      end else begin
        sync1_r[c] <= in_ch_s[c];
        sync2_r[c] <= sync1_r[c];
      end
    end
  end

  assign samp_src_s = sync2_r;
`else
  assign samp_src_s = in_ch_s;
`endif

  // Bus write decode, edge capture (set wins over W1C), strobe, read mux and irq reduction.
  always_comb begin
    rd_next_s     = {DATA_W{1'b0}};
    irq_next_s    = 1'b0;
    strobe_next_s = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      out_next_s[c]  = out_r[c];
      mask_next_s[c] = mask_r[c];
      cap_next_s[c]  = cap_r[c] | edge_evt(samp_r[c], prev_r[c]);
      irq_next_s     = irq_next_s | (|(cap_r[c] & mask_r[c]));
      if (wr_s && sel_s[c]) begin
        case (reg_s)
          REG_DATA:   out_next_s[c]  = writedata;
          REG_OUTSET: out_next_s[c]  = out_r[c] | writedata;
          REG_OUTCLR: out_next_s[c]  = out_r[c] & ~writedata;
          REG_MASK:   mask_next_s[c] = writedata;
          REG_CAP:    cap_next_s[c]  = (cap_r[c] & ~writedata) | edge_evt(samp_r[c], prev_r[c]);
          default:    out_next_s[c]  = out_r[c];
        endcase
      end else begin
        out_next_s[c] = out_r[c];
      end
      strobe_next_s[c] = (out_next_s[c] != out_r[c]);
      rd_next_s = rd_next_s | (sel_s[c] ? reg_read(reg_s, samp_r[c], out_r[c], mask_r[c], cap_r[c])
                                        : {DATA_W{1'b0}});
    end
  end

  // State and output registers; reset overrides any concurrent bus access.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        out_r[c]  <= RESET_OUT;
        mask_r[c] <= {DATA_W{1'b0}};
        cap_r[c]  <= {DATA_W{1'b0}};
        samp_r[c] <= {DATA_W{1'b0}};
        prev_r[c] <= {DATA_W{1'b0}};
      end
      readdata_r <= {DATA_W{1'b0}};
      strobe_r   <= {NUM_CH{1'b0}};
      irq_r      <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        out_r[c]  <= out_next_s[c];
        mask_r[c] <= mask_next_s[c];
        cap_r[c]  <= cap_next_s[c];
        samp_r[c] <= samp_src_s[c];
        prev_r[c] <= samp_r[c];
      end
      readdata_r <= rd_next_s;
      strobe_r   <= strobe_next_s;
      irq_r      <= irq_next_s;
    end
  end

  assign readdata   = readdata_r;
  assign out_strobe = strobe_r;
  assign irq        = irq_r;

endmodule

// File: tb/tb_hps_layer_pio_multi.sv
// Scoreboard bench for hps_layer_pio_multi: a per-cycle register-map model queues expected
// outputs, a negedge monitor compares them; directed test-plan steps add constant checks.
module tb_hps_layer_pio_multi;
  localparam int          DW   = 32;
  localparam int          NCH  = 4;
  localparam int          AW   = 6;
  localparam logic [31:0] ROUT = 32'hA5A5_0F0F;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [127:0]  in_port;
  logic [127:0]  out_port;
  logic [3:0]    out_strobe;
  logic          irq;

  hps_layer_pio_multi #(
    .DATA_W(DW), .NUM_CH(NCH), .EDGE_TYPE(0), .RESET_OUT(ROUT), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .out_strobe(out_strobe), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  rd;
    logic [127:0] out;
    logic [3:0]   stb;
    logic         irq;
  } exp_t;

  exp_t         q[$];
  exp_t         e;
  int           total = 0;
  int           bad   = 0;
  logic [31:0]  m_out[NCH], m_mask[NCH], m_cap[NCH], m_s[NCH], m_prev[NCH];
  logic [127:0] in_v;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: one expectation per clock edge, compared on the following falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      check("readdata",   {96'd0, readdata},    {96'd0, e.rd});
      check("out_port",   out_port,             e.out);
      check("out_strobe", {124'd0, out_strobe}, {124'd0, e.stb});
      check("irq",        {127'd0, irq},        {127'd0, e.irq});
    end
  end

  // Drive one cycle, advance the reference model across that edge, queue the expectation.
  task automatic step(input logic rst, input logic cs, input logic wn,
                      input logic [5:0] a, input logic [31:0] wd);
    exp_t        x;
    int          ch;
    int          r;
    logic [31:0] evt[NCH];
    logic [31:0] nout[NCH];
    logic [31:0] ncap[NCH];
    reset = rst; chipselect = cs; write_n = wn; address = a; writedata = wd; in_port = in_v;
    ch = int'(a[5:3]);
    r  = int'(a[2:0]);
    x.stb = 4'd0;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_out[c] = ROUT; m_mask[c] = 32'd0; m_cap[c] = 32'd0; m_s[c] = 32'd0; m_prev[c] = 32'd0;
      end
      x.rd  = 32'd0;
      x.irq = 1'b0;
    end else begin
      x.rd = 32'd0;
      if (ch < NCH) begin
        case (r)
          0:       x.rd = m_s[ch];
          1:       x.rd = m_out[ch];
          4:       x.rd = m_mask[ch];
          5:       x.rd = m_cap[ch];
          default: x.rd = 32'd0;
        endcase
      end
      x.irq = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        if ((m_cap[c] & m_mask[c]) != 32'd0) x.irq = 1'b1;
        evt[c]  = m_s[c] & ~m_prev[c];
        ncap[c] = m_cap[c] | evt[c];
        nout[c] = m_out[c];
      end
      if (cs && !wn && ch < NCH) begin
        case (r)
          0:       nout[ch]   = wd;
          2:       nout[ch]   = m_out[ch] | wd;
          3:       nout[ch]   = m_out[ch] & ~wd;
          4:       m_mask[ch] = wd;
          5:       ncap[ch]   = (m_cap[ch] & ~wd) | evt[ch];
          default: ;
        endcase
      end
      for (int c = 0; c < NCH; c++) begin
        x.stb[c]  = (nout[c] != m_out[c]);
        m_out[c]  = nout[c];
        m_cap[c]  = ncap[c];
        m_prev[c] = m_s[c];
        m_s[c]    = in_v[c*32 +: 32];
      end
    end
    for (int c = 0; c < NCH; c++) x.out[c*32 +: 32] = m_out[c];
    q.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [5:0] ad(input int ch, input int r);
    return 6'(ch * 8 + r);
  endfunction

  task automatic wr(input int ch, input int r, input logic [31:0] wd);
    step(1'b0, 1'b1, 1'b0, ad(ch, r), wd);
  endtask

  task automatic rd(input int ch, input int r);
    step(1'b0, 1'b1, 1'b1, ad(ch, r), $urandom());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom());
  endtask

  initial begin
    in_v = 128'd0;
    repeat (3) step(1'b1, 1'b0, 1'b1, 6'd0, 32'd0);

    for (int c = 0; c < NCH; c++) begin
      rd(c, 1);
      check("reset_out_rb", {96'd0, readdata}, {96'd0, ROUT});
    end
    check("reset_irq",    {127'd0, irq},        128'd0);
    check("reset_strobe", {124'd0, out_strobe}, 128'd0);

    wr(1, 0, 32'h0000_00F0);
    check("ch1_data",        {96'd0, out_port[63:32]}, 128'hF0);
    check("ch1_data_strobe", {124'd0, out_strobe},     128'h2);
    idle(1);
    check("strobe_one_cycle", {124'd0, out_strobe}, 128'd0);
    wr(1, 2, 32'h0000_000F);
    check("ch1_outset",        {96'd0, out_port[63:32]}, 128'hFF);
    check("ch1_outset_strobe", {124'd0, out_strobe},     128'h2);
    wr(1, 3, 32'h0000_00F0);
    check("ch1_outclr",        {96'd0, out_port[63:32]}, 128'h0F);
    check("ch1_outclr_strobe", {124'd0, out_strobe},     128'h2);
    wr(1, 2, 32'h0000_000F);
    check("ch1_outset_nochg", {124'd0, out_strobe}, 128'd0);

    in_v[64 +: 32] = 32'h5;
    idle(3);
    rd(2, 5);
    check("ch2_edge_cap",  {96'd0, readdata}, 128'h5);
    check("ch2_irq_unmsk", {127'd0, irq},     128'd0);
    wr(2, 4, 32'h4);
    check("irq_same_cycle", {127'd0, irq}, 128'd0);
    idle(1);
    check("irq_after_mask", {127'd0, irq}, 128'd1);
    wr(2, 5, 32'h4);
    idle(1);
    check("irq_after_w1c", {127'd0, irq}, 128'd0);
    rd(2, 5);
    check("ch2_cap_after_w1c", {96'd0, readdata}, 128'h1);

    in_v[3] = 1'b1; idle(3);
    in_v[3] = 1'b0; idle(2);
    in_v[3] = 1'b1; idle(1);
    wr(0, 5, 32'h8);
    rd(0, 5);
    check("set_wins_w1c", {96'd0, readdata}, 128'h8);

    rd(4, 1);
    check("oor_channel_read", {96'd0, readdata}, 128'd0);
    rd(2, 6);
    check("reg6_read", {96'd0, readdata}, 128'd0);
    wr(5, 0, $urandom());
    wr(0, 6, $urandom());
    wr(1, 7, $urandom());
    check("oor_writes_ignored", out_port, {ROUT, ROUT, 32'h0000_000F, ROUT});

    wr(3, 0, 32'h1234_5678);
    step(1'b1, 1'b1, 1'b0, ad(3, 0), 32'hDEAD_BEEF);
    check("reset_wr_ch3",     {96'd0, out_port[127:96]}, {96'd0, ROUT});
    check("reset_wr_nostrobe", {124'd0, out_strobe},    128'd0);
    rd(2, 0);
    step(1'b1, 1'b1, 1'b1, ad(2, 0), 32'd0);
    check("reset_mid_read", {96'd0, readdata}, 128'd0);
    idle(3);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) in_v = in_v ^ (128'd1 << $urandom_range(0, 127));
      if ($urandom_range(0, 15) == 0) in_v = {$urandom(), $urandom(), $urandom(), $urandom()};
      step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 63)),
           ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 255)));
    end
    idle(2);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hps_layer_pio_multi.md
Name: hps_layer_pio_multi

Overview:
- Parametrised, multi-channel Avalon-MM PIO. Successor to the single-channel 32-bit layer PIO.
- The HPS uses it to exchange per-layer words with the MLP datapath.
- Provides NUM_CH independent in/out channel pairs, each DATA_W bits wide.
- Adds output set/clear, per-bit edge capture with interrupt mask, a single irq line and per-channel output-update strobes.

Parameters:
- DATA_W, 32, width of every in/out channel and of the bus data (1..32).
- NUM_CH, 4, number of channel pairs (1..16).
- EDGE_TYPE, 0, edge-capture event: 0 = rising, 1 = falling, 2 = any.
- RESET_OUT, 0, reset value loaded into every out channel register.
- ADDR_W, 5, address width. Must be at least clog2(NUM_CH)+3.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_W  word address: address[ADDR_W-1:3] = channel, address[2:0] = register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  DATA_W  write data.
- readdata  out  DATA_W  registered read data.
- in_port  in  NUM_CH*DATA_W  input channels; channel c = bits [c*DATA_W +: DATA_W].
- out_port  out  NUM_CH*DATA_W  output channel registers, same packing as in_port.
- out_strobe  out  NUM_CH  1-cycle pulse when the corresponding out channel value changes by a bus write.
- irq  out  1  level interrupt.

Behaviour:
- Register map, per channel c (reg = address[2:0]):
  - 0 DATA: R = sampled in; W = load out.
  - 1 OUT_RB: R = out; W ignored.
  - 2 OUTSET: W = out |= writedata; reads 0.
  - 3 OUTCLR: W = out &= ~writedata; reads 0.
  - 4 IRQ_MASK: R/W.
  - 5 EDGE_CAP: R; write-1-to-clear.
  - 6, 7: read 0, writes ignored.
- Channel index >= NUM_CH: reads 0, writes ignored.
- Write: takes effect on the clk edge where chipselect=1 and write_n=0. New value is visible on out_port the following cycle.
- readdata: registered every cycle from the current address, regardless of chipselect; 1-cycle read latency. A read issued in the same cycle as a write to the same register returns the old value.
- out_strobe[c]: asserted for exactly one cycle, coincident with the new out_port value. Only when a DATA/OUTSET/OUTCLR write actually changes the register; a write of an identical value produces no pulse.
- Sampled input s[c]: in_port channel registered once (1 cycle). prev[c] holds the previous s[c].
- Edge event, per bit:
  - EDGE_TYPE 0: s & ~prev.
  - EDGE_TYPE 1: ~s & prev.
  - EDGE_TYPE 2: s ^ prev.
- EDGE_CAP bits are sticky. An event and a W1C on the same bit in the same cycle leaves the bit set (set wins).
- irq = registered OR over all channels of (EDGE_CAP & IRQ_MASK). Rises 1 cycle after a captured bit or mask bit becomes set. Falls 1 cycle after clear or mask.
- Reset (synchronous, takes priority over any access), values:
  - out = RESET_OUT, IRQ_MASK = 0, EDGE_CAP = 0.
  - s and prev = 0, readdata = 0, out_strobe = 0, irq = 0.
- Edge detection starts from the reset values of s and prev. An input held high through reset registers one rising edge 2 cycles after reset deasserts (EDGE_TYPE 0/2).
- Reset asserted mid-read: readdata = 0 the next cycle.
- Widths: writedata bits above DATA_W do not exist. No arithmetic; all operations are bitwise.

Optional Feature:
- Macro PIO_INSYNC_EN.
- Defined: each in_port channel passes through a 2-flop synchronizer before the sample register.
  - DATA read latency from a pin change is 3 cycles.
  - Edge detection is delayed by 2 cycles.
  - Synchronizer flops reset to 0.
- Undefined: single sample register only, as described in Behaviour. Intended for in_port driven by the clk domain.

Test Plan:
- Reset, then read OUT_RB for all channels -> readdata = RESET_OUT. irq = 0, out_strobe = 0.
- Write ch1 DATA = 0x0000_00F0 -> out_port ch1 = 0xF0 the next cycle, out_strobe = 0b0010 for 1 cycle.
  - Then OUTSET 0x0F -> 0xFF with a strobe.
  - Then OUTCLR 0xF0 -> 0x0F with a strobe.
  - Then OUTSET 0x0F -> no strobe.
- EDGE_TYPE 0, ch2 in_port 0 -> 0x5 -> EDGE_CAP ch2 = 0x5; irq stays 0.
  - Write IRQ_MASK ch2 = 0x4 -> irq = 1 one cycle later.
  - W1C EDGE_CAP 0x4 -> irq = 0; EDGE_CAP reads 0x1.
- Rising edge on ch0 bit3 in the same cycle as W1C 0x8 -> bit3 stays set.
- Read channel index NUM_CH (out of range) and reg 6 -> readdata = 0. Writes there leave all out_port unchanged.
- Assert reset during a DATA write to ch3 -> out_port ch3 = RESET_OUT, no strobe.
- With PIO_INSYNC_EN defined, DATA read reflects an in_port change 3 cycles after the change.
